// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports (cpu, ldr) and unified-memory port of the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ldr_req, ldr_we, ldr_ack;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write, busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_ack, ldr_ack, rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_ack, ldr_ack, rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting a cpu port and a loader port access to one memory.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d, owner_q, owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              pick;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // owner encoding matches last_grant: 0 = cpu, 1 = ldr; a tie goes to the one not served last
  always_comb begin
    pick    = (bus.cpu_req && bus.ldr_req) ? ~last_q : bus.ldr_req;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.cpu_req || bus.ldr_req) begin
        state_d = ACCESS;
        cnt_d   = '0;
        owner_d = pick;
        we_d    = pick ? bus.ldr_we : bus.cpu_we;
        addr_d  = pick ? bus.ldr_addr : bus.cpu_addr;
        wdata_d = pick ? bus.ldr_wdata : bus.cpu_wdata;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = DONE;
          rdata_d = we_q ? rdata_q : bus.mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.mem_read  = state_q == ACCESS && !we_q;
  assign bus.mem_write = state_q == ACCESS && we_q;
  assign bus.cpu_ack   = state_q == DONE && !owner_q;
  assign bus.ldr_ack   = state_q == DONE && owner_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a transaction timeline model.
module tb_mem_arbiter;
  localparam int W = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, nvec = 0, nerr = 0;
  mem_arbiter_if a();
  mem_arbiter_if b();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .bus(a));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] phys [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] dflt(logic [31:0] ad);
    return (ad * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  // memory behind the DUT: writes land on strobe cycles, read data follows mem_addr
  initial forever begin
    @(negedge clk);
    if (a.mem_write) phys[a.mem_addr] = a.mem_wdata;
    a.mem_rdata = phys.exists(a.mem_addr) ? phys[a.mem_addr] : dflt(a.mem_addr);
  end

  // timeline model: a grant in idle cycle s gives strobes s+1..s+1+W and the ack at s+2+W
  int mcyc = 0, m_start = 0;
  logic m_act = 1'b0, m_last = 1'b1, m_own = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 1'b0; m_last = 1'b1; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      if (!m_act) begin
        if (a.cpu_req || a.ldr_req) begin
          m_own   = (a.cpu_req && a.ldr_req) ? !m_last : a.ldr_req;
          m_we    = m_own ? a.ldr_we : a.cpu_we;
          m_addr  = m_own ? a.ldr_addr : a.cpu_addr;
          m_wdata = m_own ? a.ldr_wdata : a.cpu_wdata;
          m_act   = 1'b1;
          m_start = mcyc;
        end
      end else if (mcyc == m_start + 1 + W) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else m_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
      end else if (mcyc == m_start + 2 + W) begin
        m_act  = 1'b0;
        m_last = m_own;
      end
      mcyc++;
    end
  end

  task automatic idle_inputs();
    a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
    a.ldr_req = 0; a.ldr_we = 0; a.ldr_addr = '0; a.ldr_wdata = '0;
    b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b.ldr_req = 0; b.ldr_we = 0; b.ldr_addr = '0; b.ldr_wdata = '0;
    b.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    nvec++; if ({a.cpu_ack, a.ldr_ack, a.mem_read, a.mem_write, a.busy} !== 5'b0) begin nerr++; $display("FAIL reset_ctl: got %b expected 00000", {a.cpu_ack, a.ldr_ack, a.mem_read, a.mem_write, a.busy}); end
    nvec++; if ({a.mem_addr, a.mem_wdata, a.rdata} !== 96'h0) begin nerr++; $display("FAIL reset_regs: got %h/%h/%h expected 0", a.mem_addr, a.mem_wdata, a.rdata); end
    nvec++; if ({b.cpu_ack, b.ldr_ack, b.mem_read, b.mem_write, b.busy} !== 5'b0) begin nerr++; $display("FAIL reset_ctl_w0: got %b expected 00000", {b.cpu_ack, b.ldr_ack, b.mem_read, b.mem_write, b.busy}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_cpu_read();
    int n, rd = 0, cack = 0, lack = 0, ack_at = -1;
    logic [31:0] got = '0;
    do_reset();
    phys[32'h40] = 32'hDEADBEEF; ref_mem[32'h40] = 32'hDEADBEEF;
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h40; n = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a.mem_read) rd++;
      if (a.ldr_ack) lack++;
      if (a.cpu_ack) begin cack++; if (ack_at < 0) ack_at = cyc - n; got = a.rdata; a.cpu_req = 0; end
    end
    nvec++; if (rd !== 2) begin nerr++; $display("FAIL read_strobe_len: got %0d expected 2", rd); end
    nvec++; if (ack_at !== 3) begin nerr++; $display("FAIL read_latency: got %0d expected 3", ack_at); end
    nvec++; if (got !== 32'hDEADBEEF) begin nerr++; $display("FAIL read_data: got %h expected deadbeef", got); end
    nvec++; if ({cack, lack} !== {32'd1, 32'd0}) begin nerr++; $display("FAIL read_acks: got cpu %0d ldr %0d expected 1/0", cack, lack); end
  endtask

  task automatic test_tie_from_reset();
    int nack = 0, wr = 0, badw = 0;
    logic [7:0] seq = '0;
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    a.cpu_req = 1; a.cpu_addr = 32'h20;
    a.ldr_req = 1; a.ldr_we = 1; a.ldr_addr = 32'h10; a.ldr_wdata = 32'h55;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.mem_write) begin wr++; if (a.mem_addr !== 32'h10 || a.mem_wdata !== 32'h55) badw++; end
      if (a.cpu_ack) begin seq = {seq[6:0], 1'b0}; nack++; a.cpu_req = 0; end
      if (a.ldr_ack) begin seq = {seq[6:0], 1'b1}; nack++; a.ldr_req = 0; end
    end
    nvec++; if (nack !== 2) begin nerr++; $display("FAIL tie_ack_count: got %0d expected 2", nack); end
    nvec++; if (seq[1:0] !== 2'b01) begin nerr++; $display("FAIL tie_order: got %b expected 01", seq[1:0]); end
    nvec++; if ({wr, badw} !== {32'd2, 32'd0}) begin nerr++; $display("FAIL tie_write: got %0d cycles %0d bad expected 2/0", wr, badw); end
  endtask

  task automatic test_alternation();
    int r, nack = 0, last_at = -1;
    logic [5:0] seq = '0;
    do_reset();
    a.cpu_req = 1; a.cpu_addr = 32'h4; a.ldr_req = 1; a.ldr_addr = 32'h8; r = cyc;
    for (int k = 0; k < 60 && nack < 6; k++) begin
      @(negedge clk);
      if (a.cpu_ack) begin seq = {seq[4:0], 1'b0}; nack++; end
      if (a.ldr_ack) begin seq = {seq[4:0], 1'b1}; nack++; end
      if (nack == 6) begin last_at = cyc - r; a.cpu_req = 0; a.ldr_req = 0; end
    end
    nvec++; if (nack !== 6) begin nerr++; $display("FAIL alt_count: got %0d expected 6", nack); end
    nvec++; if (seq !== 6'b010101) begin nerr++; $display("FAIL alt_order: got %b expected 010101", seq); end
    nvec++; if (last_at !== 23) begin nerr++; $display("FAIL alt_spacing: got %0d expected 23", last_at); end
  endtask

  task automatic test_wait0();
    int n, wr = 0, cack = 0, ack_at = -1;
    do_reset();
    b.ldr_req = 1; b.ldr_we = 1; b.ldr_addr = 32'h10; b.ldr_wdata = 32'h55; n = cyc;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b.mem_write) wr++;
      if (b.cpu_ack) cack++;
      if (b.ldr_ack) begin if (ack_at < 0) ack_at = cyc - n; b.ldr_req = 0; end
    end
    nvec++; if (wr !== 1) begin nerr++; $display("FAIL w0_strobe_len: got %0d expected 1", wr); end
    nvec++; if (ack_at !== 2) begin nerr++; $display("FAIL w0_latency: got %0d expected 2", ack_at); end
    nvec++; if (cack !== 0) begin nerr++; $display("FAIL w0_cpu_ack: got %0d expected 0", cack); end
  endtask

  task automatic test_reset_mid_access();
    int r, cack = 0, ack_at = -1;
    logic who = 1'b1;
    do_reset();
    a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 32'hF00; a.cpu_wdata = 32'h1234;
    @(negedge clk);
    nvec++; if (a.mem_write !== 1'b1) begin nerr++; $display("FAIL rst_pre_write: got %b expected 1", a.mem_write); end
    #1 rst_n = 0;
    #1;
    nvec++; if ({a.mem_write, a.mem_read, a.busy, a.cpu_ack} !== 4'b0) begin nerr++; $display("FAIL rst_async_drop: got %b expected 0000", {a.mem_write, a.mem_read, a.busy, a.cpu_ack}); end
    a.cpu_req = 0;
    repeat (3) begin @(negedge clk); if (a.cpu_ack) cack++; end
    rst_n = 1;
    a.cpu_req = 1; a.cpu_we = 0; a.ldr_req = 1; a.ldr_we = 0; r = cyc;
    for (int k = 0; k < 10 && ack_at < 0; k++) begin
      @(negedge clk);
      if (a.cpu_ack || a.ldr_ack) begin ack_at = cyc - r; who = a.ldr_ack; a.cpu_req = 0; a.ldr_req = 0; end
    end
    nvec++; if (cack !== 0) begin nerr++; $display("FAIL rst_no_ack: got %0d expected 0", cack); end
    nvec++; if (who !== 1'b0) begin nerr++; $display("FAIL rst_tie_owner: got %b expected 0", who); end
    nvec++; if (ack_at !== 3) begin nerr++; $display("FAIL rst_first_arb: got %0d expected 3", ack_at); end
  endtask

  task automatic test_inflight();
    int n, bad = 0, cack = 0, ack_at = -1;
    do_reset();
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h40; n = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 3 && a.mem_addr !== 32'h40) bad++;
      if (k == 1) a.cpu_addr = 32'h80;
      if (k == 2) a.cpu_req = 0;
      if (a.cpu_ack) begin cack++; ack_at = cyc - n; end
    end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL inflight_addr: got %0d bad cycles expected 0", bad); end
    nvec++; if ({cack, ack_at} !== {32'd1, 32'd3}) begin nerr++; $display("FAIL inflight_ack: got %0d at %0d expected 1 at 3", cack, ack_at); end
  endtask

  task automatic test_random();
    logic in_acc, in_done;
    logic [4:0] exp_ctl, got_ctl;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_acc  = m_act && mcyc >= m_start + 1 && mcyc <= m_start + 1 + W;
      in_done = m_act && mcyc == m_start + 2 + W;
      exp_ctl = {in_done && !m_own, in_done && m_own, in_acc && !m_we, in_acc && m_we, in_acc || in_done};
      got_ctl = {a.cpu_ack, a.ldr_ack, a.mem_read, a.mem_write, a.busy};
      nvec++; if (got_ctl !== exp_ctl) begin nerr++; $display("FAIL rnd_ctl @%0d: got %b expected %b", i, got_ctl, exp_ctl); end
      nvec++; if (a.mem_addr !== m_addr) begin nerr++; $display("FAIL rnd_addr @%0d: got %h expected %h", i, a.mem_addr, m_addr); end
      nvec++; if (a.mem_wdata !== m_wdata) begin nerr++; $display("FAIL rnd_wdata @%0d: got %h expected %h", i, a.mem_wdata, m_wdata); end
      nvec++; if (a.rdata !== m_rdata) begin nerr++; $display("FAIL rnd_rdata @%0d: got %h expected %h", i, a.rdata, m_rdata); end
      if (i % 300 == 299) begin
        rst_n = 0;
        #1;
        got_ctl = {a.cpu_ack, a.ldr_ack, a.mem_read, a.mem_write, a.busy};
        nvec++; if (got_ctl !== 5'b0) begin nerr++; $display("FAIL rnd_reset @%0d: got %b expected 00000", i, got_ctl); end
        @(negedge clk);
        rst_n = 1;
      end
      a.cpu_req = $urandom_range(0, 9) < 6; a.cpu_we = $urandom_range(0, 1) == 1;
      a.cpu_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; a.cpu_wdata = $urandom;
      a.ldr_req = $urandom_range(0, 9) < 6; a.ldr_we = $urandom_range(0, 1) == 1;
      a.ldr_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; a.ldr_wdata = $urandom;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_tie_from_reset();
    test_alternation();
    test_wait0();
    test_reset_mid_access();
    test_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports.
REQ-003 Parameter WAIT_CYCLES, default 1, extra memory wait states per access; legal range 0-15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cpu_req  in  1  CPU-side access request; held high until cpu_ack.
REQ-007 cpu_we  in  1  CPU access is a write when 1, a read when 0.
REQ-008 cpu_addr  in  ADDR_W  CPU access address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-011 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack: loader/debug port, same widths and semantics as REQ-006 to REQ-010.
REQ-012 rdata  out  DATA_W  read data returned to the requester being acked; valid only while its ack is high.
REQ-013 mem_addr  out  ADDR_W  address to the unified memory.
REQ-014 mem_wdata  out  DATA_W  write data to memory.
REQ-015 mem_read  out  1  memory read strobe.
REQ-016 mem_write  out  1  memory write strobe.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid in the last strobe cycle.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; IDLE->ACCESS on any req, ACCESS->DONE when the wait counter reaches WAIT_CYCLES, DONE->IDLE unconditionally.
REQ-020 In IDLE with exactly one req high, that requester is granted.
REQ-021 In IDLE with both reqs high, grant goes to the requester not granted last (round-robin pointer last_grant: 0=cpu, 1=ldr).
REQ-022 On grant, the owner, we, addr and wdata are latched; later requester input changes do not affect the access in flight.
REQ-023 In ACCESS, mem_addr/mem_wdata carry the latched values, and mem_read (we=0) or mem_write (we=1) is held high for exactly WAIT_CYCLES+1 cycles; both strobes are never high together.
REQ-024 The 4-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle.
REQ-025 mem_rdata is captured into rdata on the last ACCESS cycle of a read; rdata holds its value otherwise.
REQ-026 In DONE, only the owner's ack is high, for exactly one cycle; last_grant is updated to the owner.
REQ-027 Latency: req first sampled in IDLE at cycle N -> strobes in cycles N+1..N+1+WAIT_CYCLES -> ack in cycle N+2+WAIT_CYCLES.
REQ-028 Deassertion of the owner's req during ACCESS does not abort the access; ack still pulses.
REQ-029 A req still high in the cycle after its ack is treated as a new request and arbitrated normally; IDLE lasts at least one cycle between accesses.
REQ-030 Strobes and acks are low in IDLE; mem_addr and mem_wdata hold their last values.

Reset
REQ-031 While rst_n=0, state=IDLE, counter=0, last_grant=1, and cpu_ack, ldr_ack, mem_read, mem_write and busy are 0 immediately, without waiting for a clock edge.
REQ-032 rdata, mem_addr and mem_wdata reset to 0.
REQ-033 Reset during ACCESS drops the strobes at once, issues no ack and discards the access; after release, the first tie is granted to the CPU.
REQ-034 The first arbitration occurs on the first rising edge with rst_n=1.

Verification
REQ-035 WAIT_CYCLES=1, CPU read addr 0x40, mem_rdata=0xDEADBEEF -> mem_read high for 2 cycles, cpu_ack in cycle N+3, rdata=0xDEADBEEF, ldr_ack stays 0.
REQ-036 Both req high from reset, loader write 0x10<-0x55 and CPU read 0x20 -> CPU served first, then loader; mem_write for 0x10 with wdata 0x55; each ack pulses once.
REQ-037 Both reqs held high for 6 accesses -> grants alternate cpu, ldr, cpu, ldr, cpu, ldr.
REQ-038 WAIT_CYCLES=0, single loader write -> one mem_write cycle, ldr_ack in cycle N+2.
REQ-039 rst_n pulled low mid-ACCESS of a CPU write -> mem_write low in the same cycle, no cpu_ack; after release, a tie is granted to the CPU.
REQ-040 CPU changes cpu_addr from 0x40 to 0x80 mid-ACCESS -> mem_addr stays 0x40 until DONE.
